// File: rtl/mem_access.sv
// Memory-access stage: effective address, variable-latency load/store over a
// req/ack bus, load formatting, and a registered valid/ready writeback output.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] r0data_i,
  input  logic [31:0] r1data_i,
  input  logic [31:0] result_i,
  output logic        valid_ro,
  input  logic        ready_i,
  output logic [31:0] pc_ro,
  output logic [31:0] inst_ro,
  output logic [31:0] result_ro,
  output logic        misalign_ro,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [31:0] pc_q, inst_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        is_load, is_store, misalign, accept, out_free, mem_go;
  logic [2:0]  funct3;
  logic [31:0] imm, ea, wdata_c, shifted, load_data;
  logic [3:0]  wstrb_c;

  assign is_load  = (inst_i[6:0] == 7'b0000011);
  assign is_store = (inst_i[6:0] == 7'b0100011);
  assign funct3   = inst_i[14:12];
  assign imm      = is_store ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]}
                             : {{20{inst_i[31]}}, inst_i[31:20]};
  assign ea       = r0data_i + imm;

  always_comb begin
    misalign = 1'b0;
    if (is_load || is_store) begin
      case (funct3[1:0])
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = ea[0];
        default: misalign = |ea[1:0];
      endcase
    end
  end

  // Entering BUSY is only possible when ready_o = 1, so the output register
  // is guaranteed free by the time the ack arrives.
  assign out_free = ~valid_ro | ready_i;
  assign ready_o  = (state == IDLE) & out_free;
  assign accept   = valid_i & ready_o;
  assign mem_go   = accept & (is_load | is_store) & ~misalign;

  always_comb begin
    wdata_c = r1data_i;
    wstrb_c = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_c = {4{r1data_i[7:0]}};
        wstrb_c = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        wdata_c = {2{r1data_i[15:0]}};
        wstrb_c = 4'b0011 << ea[1:0];
      end
      default: ;
    endcase
  end

  // Halves are aligned, so shifting by the byte lane also selects the half.
  assign shifted = dmem_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    load_data = dmem_rdata_i;
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{~funct3_q[2] & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      valid_ro     <= 1'b0;
      pc_ro        <= '0;
      inst_ro      <= '0;
      result_ro    <= '0;
      misalign_ro  <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_wstrb_o <= '0;
      pc_q         <= '0;
      inst_q       <= '0;
      funct3_q     <= '0;
      lane_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_go) begin
            state        <= BUSY;
            pc_q         <= pc_i;
            inst_q       <= inst_i;
            funct3_q     <= funct3;
            lane_q       <= ea[1:0];
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_store;
            dmem_addr_o  <= {ea[31:2], 2'b00};
            dmem_wdata_o <= is_store ? wdata_c : 32'h0;
            dmem_wstrb_o <= is_store ? wstrb_c : 4'b0000;
            if (ready_i) valid_ro <= 1'b0;
          end else if (accept) begin
            valid_ro    <= 1'b1;
            pc_ro       <= pc_i;
            inst_ro     <= inst_i;
            result_ro   <= misalign ? ea : result_i;
            misalign_ro <= misalign;
          end else if (ready_i) begin
            valid_ro <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack_i && out_free) begin
            state       <= IDLE;
            dmem_req_o  <= 1'b0;
            valid_ro    <= 1'b1;
            pc_ro       <= pc_q;
            inst_ro     <= inst_q;
            result_ro   <= dmem_we_o ? {dmem_addr_o[31:2], lane_q} : load_data;
            misalign_ro <= 1'b0;
          end else if (ready_i) begin
            valid_ro <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
